// File: rtl/pa_sysmap_tcipif_master.sv
// TCIPIF initiator for the system-map block: one bus transaction per request,
// with cycle timeout and alignment check folded into the response error flag.
module pa_sysmap_tcipif_master #(
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter int unsigned CNT_W       = 8
) (
    input  logic        forever_cpuclk,
    input  logic        cpurst,
    input  logic        req_vld,
    output logic        req_rdy,
    input  logic        req_write,
    input  logic [15:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_vld,
    input  logic        rsp_rdy,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        tcipif_sysmap_sel,
    output logic [15:0] tcipif_sysmap_addr,
    output logic        tcipif_sysmap_write,
    output logic [31:0] tcipif_sysmap_wdata,
    input  logic        sysmap_tcipif_cmplt,
    input  logic [31:0] sysmap_tcipif_rdata
);

    // With the timeout disabled the counter saturates at all-ones instead.
    localparam bit               LP_TO_EN = (TIMEOUT_CYC != 0);
    localparam logic [CNT_W-1:0] LP_CMP   = (TIMEOUT_CYC == 0) ? {CNT_W{1'b1}}
                                                               : CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    logic        r_req_rdy;
    logic        r_rsp_vld;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_err;
    logic        r_sel;
    logic [15:0] r_addr;
    logic        r_write;
    logic [31:0] r_wdata;

    logic [31:0] w_rdata_nxt;
    logic        w_err_nxt;
    logic [15:0] w_addr_nxt;
    logic        w_write_nxt;
    logic [31:0] w_wdata_nxt;

    // Next-state and next-value logic for every registered output.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rdata_nxt = r_rsp_rdata;
        w_err_nxt   = r_rsp_err;
        w_addr_nxt  = r_addr;
        w_write_nxt = r_write;
        w_wdata_nxt = r_wdata;

        case (r_state)
            ST_IDLE: begin
                if (req_vld && r_req_rdy) begin
                    if (req_addr[1:0] == 2'b00) begin
                        w_addr_nxt  = req_addr;
                        w_write_nxt = req_write;
                        w_wdata_nxt = req_wdata;
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_BUSY;
                    end else begin
                        w_err_nxt   = 1'b1;
                        w_rdata_nxt = 32'd0;
                        w_state_nxt = ST_RESP;
                    end
                end
            end
            ST_BUSY: begin
                // Completion takes priority over a timeout in the same cycle.
                if (sysmap_tcipif_cmplt) begin
                    w_rdata_nxt = r_write ? 32'd0 : sysmap_tcipif_rdata;
                    w_err_nxt   = 1'b0;
                    w_state_nxt = ST_RESP;
                end else begin
                    if (r_cnt != LP_CMP) begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                    if (LP_TO_EN && (r_cnt == LP_CMP)) begin
                        w_err_nxt   = 1'b1;
                        w_rdata_nxt = 32'd0;
                        w_state_nxt = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                if (rsp_rdy) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register; handshake and select outputs are decoded from the next state.
    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_req_rdy   <= 1'b0;
            r_rsp_vld   <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 1'b0;
            r_sel       <= 1'b0;
            r_addr      <= 16'd0;
            r_write     <= 1'b0;
            r_wdata     <= 32'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_req_rdy   <= (w_state_nxt == ST_IDLE);
            r_rsp_vld   <= (w_state_nxt == ST_RESP);
            r_rsp_rdata <= w_rdata_nxt;
            r_rsp_err   <= w_err_nxt;
            r_sel       <= (w_state_nxt == ST_BUSY);
            r_addr      <= w_addr_nxt;
            r_write     <= w_write_nxt;
            r_wdata     <= w_wdata_nxt;
        end
    end

    assign req_rdy             = r_req_rdy;
    assign rsp_vld             = r_rsp_vld;
    assign rsp_rdata           = r_rsp_rdata;
    assign rsp_err             = r_rsp_err;
    assign tcipif_sysmap_sel   = r_sel;
    assign tcipif_sysmap_addr  = r_addr;
    assign tcipif_sysmap_write = r_write;
    assign tcipif_sysmap_wdata = r_wdata;

endmodule
